// File: rtl/mdr_rs_if.sv
`default_nettype none
// ============================================================================
// Module      : mdr_rs_if
// Description : Bundle of the signals between the multiply reservation
//               station, its dispatch/CDB environment and the multiplier.
//               slave  : the reservation station side
//               master : the environment (dispatch, CDB, multiplier) side
// Revision    : 1.0  initial release
// ============================================================================
interface mdr_rs_if;
    // Pipeline control
    logic        flush;
    // Dispatch handshake and payload
    logic        disp_valid;
    logic        disp_ready;
    logic [2:0]  disp_funct3;
    logic [2:0]  disp_rob_idx;
    logic        disp_rs1_rdy;
    logic [2:0]  disp_rs1_tag;
    logic [31:0] disp_rs1_val;
    logic        disp_rs2_rdy;
    logic [2:0]  disp_rs2_tag;
    logic [31:0] disp_rs2_val;
    // Common data bus broadcast
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic [31:0] cdb_data;
    // Multiplier issue side
    logic        mdr_start;
    logic [2:0]  mdr_funct3;
    logic [31:0] mdr_rs1_data;
    logic [31:0] mdr_rs2_data;
    logic [2:0]  exe_rob_idx;
    logic        mdr_o_valid;
    logic        mdr_squash;

    modport slave (
        input  flush,
        input  disp_valid, disp_funct3, disp_rob_idx,
        input  disp_rs1_rdy, disp_rs1_tag, disp_rs1_val,
        input  disp_rs2_rdy, disp_rs2_tag, disp_rs2_val,
        input  cdb_valid, cdb_tag, cdb_data,
        input  mdr_o_valid,
        output disp_ready,
        output mdr_start, mdr_funct3, mdr_rs1_data, mdr_rs2_data, exe_rob_idx,
        output mdr_squash
    );

    modport master (
        output flush,
        output disp_valid, disp_funct3, disp_rob_idx,
        output disp_rs1_rdy, disp_rs1_tag, disp_rs1_val,
        output disp_rs2_rdy, disp_rs2_tag, disp_rs2_val,
        output cdb_valid, cdb_tag, cdb_data,
        output mdr_o_valid,
        input  disp_ready,
        input  mdr_start, mdr_funct3, mdr_rs1_data, mdr_rs2_data, exe_rob_idx,
        input  mdr_squash
    );
endinterface
`default_nettype wire

// File: rtl/mdr_rs.sv
`default_nettype none
// ============================================================================
// Module      : mdr_rs
// Description : Reservation station in front of a multi-cycle multiplier.
//               Holds DEPTH waiting ops, wakes operands from the CDB, and
//               issues one op at a time to the multiplier (IDLE/BUSY).
// Ports       : clk  - clock, rising edge
//               rst  - synchronous active-high reset
//               bus  - mdr_rs_if.slave: flush, dispatch handshake/payload,
//                      CDB broadcast, multiplier start/operands/done/squash
// Parameters  : DEPTH - number of entries (power of two, 2..8)
// Options     : MDR_RS_AGE_EN - when defined, issue the oldest ready entry
//               (age matrix); otherwise the lowest-index ready entry.
// Revision    : 1.0  initial release
// ============================================================================
module mdr_rs #(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    mdr_rs_if.slave  bus
);

    localparam int IDXW = $clog2(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Entry storage
    // ------------------------------------------------------------------
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] rs1_rdy_q;
    logic [DEPTH-1:0] rs2_rdy_q;
    logic [2:0]       funct3_q  [DEPTH];
    logic [2:0]       rob_q     [DEPTH];
    logic [2:0]       rs1_tag_q [DEPTH];
    logic [2:0]       rs2_tag_q [DEPTH];
    logic [31:0]      rs1_val_q [DEPTH];
    logic [31:0]      rs2_val_q [DEPTH];

    // Issue unit state and the registered multiplier-facing outputs
    state_t           state_q;
    logic             start_q;
    logic             squash_q;
    logic [2:0]       iss_funct3_q;
    logic [2:0]       iss_rob_q;
    logic [31:0]      iss_rs1_q;
    logic [31:0]      iss_rs2_q;

    // ------------------------------------------------------------------
    // Dispatch side
    // ------------------------------------------------------------------
    logic             w_full;
    logic             w_disp_fire;
    logic [IDXW-1:0]  w_free_idx;
    logic             w_byp1;
    logic             w_byp2;
    logic             w_d_rs1_rdy;
    logic             w_d_rs2_rdy;
    logic [31:0]      w_d_rs1_val;
    logic [31:0]      w_d_rs2_val;

    // Readiness comes only from registered valid bits, so a slot freed by
    // issue this cycle is not offered to dispatch until the next cycle.
    assign w_full          = &valid_q;
    assign bus.disp_ready  = ~w_full;
    assign w_disp_fire     = bus.disp_valid & ~w_full & ~bus.flush;

    // Lowest-index free slot (descending scan so the lowest one wins).
    always_comb begin
        w_free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                w_free_idx = IDXW'(i);
            end
        end
    end

    // An operand still waiting at dispatch may be produced on the CDB in
    // the very same cycle; capture it here or the broadcast would be lost.
    assign w_byp1      = ~bus.disp_rs1_rdy & bus.cdb_valid & (bus.disp_rs1_tag == bus.cdb_tag);
    assign w_byp2      = ~bus.disp_rs2_rdy & bus.cdb_valid & (bus.disp_rs2_tag == bus.cdb_tag);
    assign w_d_rs1_rdy = bus.disp_rs1_rdy | w_byp1;
    assign w_d_rs2_rdy = bus.disp_rs2_rdy | w_byp2;
    assign w_d_rs1_val = w_byp1 ? bus.cdb_data : bus.disp_rs1_val;
    assign w_d_rs2_val = w_byp2 ? bus.cdb_data : bus.disp_rs2_val;

    // ------------------------------------------------------------------
    // Selection
    // ------------------------------------------------------------------
    logic [DEPTH-1:0] w_ready_vec;
    logic             w_can_sel;
    logic             w_sel_valid;
    logic [IDXW-1:0]  w_sel_idx;
    logic             w_sel_fire;

    // Registered ready bits only: an operand woken this cycle becomes
    // selectable next cycle.
    assign w_ready_vec = valid_q & rs1_rdy_q & rs2_rdy_q;

    // A done pulse frees the unit in the same cycle so back-to-back ops
    // lose no cycle. Nothing issues in a flush cycle: the waiting entries
    // are being squashed.
    assign w_can_sel  = ~bus.flush &
                        ((state_q == ST_IDLE) | ((state_q == ST_BUSY) & bus.mdr_o_valid));
    assign w_sel_fire = w_can_sel & w_sel_valid;

`ifdef MDR_RS_AGE_EN
    // older_q[i][j] set means entry i was dispatched before entry j.
    // Rows/columns of free slots hold stale bits; they are rewritten when
    // the slot is next dispatched and are masked by w_ready_vec meanwhile.
    logic [DEPTH-1:0] older_q [DEPTH];

    always_comb begin
        logic w_beaten;
        w_sel_valid = 1'b0;
        w_sel_idx   = '0;
        w_beaten    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            w_beaten = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                if ((j != i) && w_ready_vec[j] && older_q[j][i]) begin
                    w_beaten = 1'b1;
                end
            end
            if (w_ready_vec[i] && !w_beaten && !w_sel_valid) begin
                w_sel_valid = 1'b1;
                w_sel_idx   = IDXW'(i);
            end
        end
    end

    // A newly dispatched entry is younger than everything already present.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                older_q[i] <= '0;
            end
        end else if (w_disp_fire) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (IDXW'(j) != w_free_idx) begin
                    older_q[w_free_idx][j] <= 1'b0;
                    older_q[j][w_free_idx] <= 1'b1;
                end
            end
        end
    end
`else
    // Fixed priority: lowest-index ready entry.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_ready_vec[i] && !w_sel_valid) begin
                w_sel_valid = 1'b1;
                w_sel_idx   = IDXW'(i);
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Entries, issue FSM and issue register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= '0;
            state_q      <= ST_IDLE;
            start_q      <= 1'b0;
            squash_q     <= 1'b0;
            iss_funct3_q <= '0;
            iss_rob_q    <= '0;
            iss_rs1_q    <= '0;
            iss_rs2_q    <= '0;
        end else begin
            start_q <= w_sel_fire;

            // Operand wakeup from the CDB.
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && !rs1_rdy_q[i] && bus.cdb_valid &&
                    (rs1_tag_q[i] == bus.cdb_tag)) begin
                    rs1_rdy_q[i] <= 1'b1;
                    rs1_val_q[i] <= bus.cdb_data;
                end
                if (valid_q[i] && !rs2_rdy_q[i] && bus.cdb_valid &&
                    (rs2_tag_q[i] == bus.cdb_tag)) begin
                    rs2_rdy_q[i] <= 1'b1;
                    rs2_val_q[i] <= bus.cdb_data;
                end
            end

            // Issue state. A flush while BUSY leaves the in-flight op
            // running; its eventual result is only marked stale.
            if (state_q == ST_IDLE) begin
                if (w_sel_fire) begin
                    state_q <= ST_BUSY;
                end
            end else begin
                if (bus.mdr_o_valid) begin
                    state_q  <= w_sel_fire ? ST_BUSY : ST_IDLE;
                    squash_q <= 1'b0;
                end else if (bus.flush) begin
                    squash_q <= 1'b1;
                end
            end

            if (w_sel_fire) begin
                valid_q[w_sel_idx] <= 1'b0;
                iss_funct3_q       <= funct3_q[w_sel_idx];
                iss_rob_q          <= rob_q[w_sel_idx];
                iss_rs1_q          <= rs1_val_q[w_sel_idx];
                iss_rs2_q          <= rs2_val_q[w_sel_idx];
            end

            if (bus.flush) begin
                valid_q <= '0;
            end

            // Dispatch targets a slot that was free this cycle, so it never
            // collides with the entry being issued or woken.
            if (w_disp_fire) begin
                valid_q[w_free_idx]   <= 1'b1;
                funct3_q[w_free_idx]  <= bus.disp_funct3;
                rob_q[w_free_idx]     <= bus.disp_rob_idx;
                rs1_rdy_q[w_free_idx] <= w_d_rs1_rdy;
                rs1_tag_q[w_free_idx] <= bus.disp_rs1_tag;
                rs1_val_q[w_free_idx] <= w_d_rs1_val;
                rs2_rdy_q[w_free_idx] <= w_d_rs2_rdy;
                rs2_tag_q[w_free_idx] <= bus.disp_rs2_tag;
                rs2_val_q[w_free_idx] <= w_d_rs2_val;
            end
        end
    end

    assign bus.mdr_start    = start_q;
    assign bus.mdr_squash   = squash_q;
    assign bus.mdr_funct3   = iss_funct3_q;
    assign bus.exe_rob_idx  = iss_rob_q;
    assign bus.mdr_rs1_data = iss_rs1_q;
    assign bus.mdr_rs2_data = iss_rs2_q;

endmodule
`default_nettype wire

// File: tb/tb_mdr_rs.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdr_rs
// Description : Self-checking bench for mdr_rs: directed scenarios plus a
//               randomized run against a cycle-level behavioural model.
//               A simple multiplier model returns mdr_o_valid mul_lat cycles
//               after each mdr_start.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mdr_rs;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mdr_rs_if bus ();

    mdr_rs #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int mul_cnt  = 0;
    int mul_lat  = 12;

    task automatic clear_inputs();
        bus.flush        = 1'b0;
        bus.disp_valid   = 1'b0;
        bus.disp_funct3  = '0;
        bus.disp_rob_idx = '0;
        bus.disp_rs1_rdy = 1'b0;
        bus.disp_rs1_tag = '0;
        bus.disp_rs1_val = '0;
        bus.disp_rs2_rdy = 1'b0;
        bus.disp_rs2_tag = '0;
        bus.disp_rs2_val = '0;
        bus.cdb_valid    = 1'b0;
        bus.cdb_tag      = '0;
        bus.cdb_data     = '0;
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    // Also runs the multiplier model that generates mdr_o_valid.
    task automatic step();
        @(posedge clk);
        #1;
        bus.mdr_o_valid = 1'b0;
        if (mul_cnt > 0) begin
            mul_cnt--;
            if (mul_cnt == 0) bus.mdr_o_valid = 1'b1;
        end
        if (bus.mdr_start === 1'b1) mul_cnt = mul_lat;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        mul_cnt = 0;
        bus.mdr_o_valid = 1'b0;
        step();
        step();
        mul_cnt = 0;
        bus.mdr_o_valid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic set_disp(input logic [2:0] f3, input logic [2:0] rob,
                            input logic r1rdy, input logic [2:0] r1tag, input logic [31:0] r1val,
                            input logic r2rdy, input logic [2:0] r2tag, input logic [31:0] r2val);
        bus.disp_valid   = 1'b1;
        bus.disp_funct3  = f3;
        bus.disp_rob_idx = rob;
        bus.disp_rs1_rdy = r1rdy;
        bus.disp_rs1_tag = r1tag;
        bus.disp_rs1_val = r1val;
        bus.disp_rs2_rdy = r2rdy;
        bus.disp_rs2_tag = r2tag;
        bus.disp_rs2_val = r2val;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        mul_cnt = 0;
        // A dispatch held during reset must be discarded.
        set_disp(3'd0, 3'd1, 1'b1, 3'd0, 32'd1, 1'b1, 3'd0, 32'd2);
        step();
        step();
        checks++;
        if (bus.disp_ready !== 1'b1) begin
            failures++; $display("FAIL reset_disp_ready: got %b want 1", bus.disp_ready);
        end
        checks++;
        if (bus.mdr_start !== 1'b0 || bus.mdr_squash !== 1'b0) begin
            failures++; $display("FAIL reset_start_squash: got %b%b want 00", bus.mdr_start, bus.mdr_squash);
        end
        checks++;
        if ({bus.mdr_funct3, bus.exe_rob_idx, bus.mdr_rs1_data, bus.mdr_rs2_data} !== 70'd0) begin
            failures++; $display("FAIL reset_issue_reg: got %h want 0",
                {bus.mdr_funct3, bus.exe_rob_idx, bus.mdr_rs1_data, bus.mdr_rs2_data});
        end
        rst = 1'b0;
        clear_inputs();
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (bus.mdr_start !== 1'b0) begin
                failures++; $display("FAIL reset_drop_dispatch c%0d: got start=%b want 0", c, bus.mdr_start);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_latency();
        logic [69:0] want;
        do_reset();
        mul_lat = 12;
        want = {3'd0, 3'd2, 32'd7, 32'd6};
        set_disp(3'd0, 3'd2, 1'b1, 3'd0, 32'd7, 1'b1, 3'd0, 32'd6);
        step();                         // cycle 1
        clear_inputs();
        checks++;
        if (bus.mdr_start !== 1'b0) begin
            failures++; $display("FAIL lat_c1_start: got %b want 0", bus.mdr_start);
        end
        step();                         // cycle 2
        checks++;
        if (bus.mdr_start !== 1'b1 ||
            {bus.mdr_funct3, bus.exe_rob_idx, bus.mdr_rs1_data, bus.mdr_rs2_data} !== want) begin
            failures++; $display("FAIL lat_c2_issue: got start=%b data=%h want start=1 data=%h", bus.mdr_start,
                {bus.mdr_funct3, bus.exe_rob_idx, bus.mdr_rs1_data, bus.mdr_rs2_data}, want);
        end
        for (int c = 3; c <= 16; c++) begin
            step();
            checks++;
            if (bus.mdr_start !== 1'b0 ||
                {bus.mdr_funct3, bus.exe_rob_idx, bus.mdr_rs1_data, bus.mdr_rs2_data} !== want) begin
                failures++; $display("FAIL lat_stable c%0d: got start=%b data=%h want start=0 data=%h", c,
                    bus.mdr_start, {bus.mdr_funct3, bus.exe_rob_idx, bus.mdr_rs1_data, bus.mdr_rs2_data}, want);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_wakeup();
        do_reset();
        mul_lat = 12;
        set_disp(3'd1, 3'd1, 1'b1, 3'd0, 32'd3, 1'b0, 3'd5, 32'd0);
        step();                         // cycle 1
        clear_inputs();
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if (bus.mdr_start !== 1'b0) begin
                failures++; $display("FAIL wake_early_start c%0d: got %b want 0", c, bus.mdr_start);
            end
            clear_inputs();
            if (c == 2) begin           // unrelated tag must not wake rs2
                bus.cdb_valid = 1'b1; bus.cdb_tag = 3'd4; bus.cdb_data = 32'hDEAD;
            end
            if (c == 3) begin
                bus.cdb_valid = 1'b1; bus.cdb_tag = 3'd5; bus.cdb_data = 32'h10;
            end
            step();
        end
        clear_inputs();                 // now cycle 5
        checks++;
        if (bus.mdr_start !== 1'b1 ||
            {bus.mdr_funct3, bus.exe_rob_idx, bus.mdr_rs1_data, bus.mdr_rs2_data} !== {3'd1, 3'd1, 32'd3, 32'h10}) begin
            failures++; $display("FAIL wake_issue: got start=%b data=%h want start=1 data=%h", bus.mdr_start,
                {bus.mdr_funct3, bus.exe_rob_idx, bus.mdr_rs1_data, bus.mdr_rs2_data}, {3'd1, 3'd1, 32'd3, 32'h10});
        end
        repeat (14) step();
    endtask

    // ------------------------------------------------------------------
    task automatic test_bypass();
        do_reset();
        mul_lat = 12;
        // Non-MUL funct3 value travels through unchanged.
        set_disp(3'b101, 3'd5, 1'b0, 3'd6, 32'd0, 1'b1, 3'd0, 32'd2);
        bus.cdb_valid = 1'b1; bus.cdb_tag = 3'd6; bus.cdb_data = 32'hAB;
        step();                         // cycle 1
        clear_inputs();
        checks++;
        if (bus.mdr_start !== 1'b0) begin
            failures++; $display("FAIL byp_c1_start: got %b want 0", bus.mdr_start);
        end
        step();                         // cycle 2
        checks++;
        if (bus.mdr_start !== 1'b1 ||
            {bus.mdr_funct3, bus.exe_rob_idx, bus.mdr_rs1_data, bus.mdr_rs2_data} !== {3'b101, 3'd5, 32'hAB, 32'd2}) begin
            failures++; $display("FAIL byp_issue: got start=%b data=%h want start=1 data=%h", bus.mdr_start,
                {bus.mdr_funct3, bus.exe_rob_idx, bus.mdr_rs1_data, bus.mdr_rs2_data}, {3'b101, 3'd5, 32'hAB, 32'd2});
        end
        repeat (14) step();
    endtask

    // ------------------------------------------------------------------
    task automatic test_full();
        logic [2:0] got[$];
        logic [2:0] want[4];
`ifdef MDR_RS_AGE_EN
        want = '{3'd0, 3'd1, 3'd2, 3'd3};
`else
        want = '{3'd1, 3'd0, 3'd2, 3'd3};
`endif
        do_reset();
        mul_lat = 12;
        set_disp(3'd0, 3'd7, 1'b1, 3'd0, 32'd1, 1'b1, 3'd0, 32'd1);
        step();                         // cycle 1: op 7 selected, unit busy till 14
        for (int k = 0; k < 4; k++) begin
            set_disp(3'd0, 3'(k), 1'b1, 3'd0, 32'(10 + k), 1'b1, 3'd0, 32'(20 + k));
            checks++;
            if (bus.disp_ready !== 1'b1) begin
                failures++; $display("FAIL full_fill_ready k%0d: got %b want 1", k, bus.disp_ready);
            end
            step();
        end
        // cycle 5: full; a fifth op is offered until cycle 13.
        set_disp(3'd0, 3'd5, 1'b1, 3'd0, 32'd99, 1'b1, 3'd0, 32'd99);
        for (int c = 5; c <= 14; c++) begin
            if (c == 14) begin
                clear_inputs();
                mul_lat = 3;
            end
            checks++;
            if (bus.disp_ready !== 1'b0) begin
                failures++; $display("FAIL full_ready_low c%0d: got %b want 0", c, bus.disp_ready);
            end
            step();
        end
        checks++;                       // cycle 15
        if (bus.disp_ready !== 1'b1 || bus.mdr_start !== 1'b1) begin
            failures++; $display("FAIL full_after_issue: got ready=%b start=%b want 1 1", bus.disp_ready, bus.mdr_start);
        end
        if (bus.mdr_start === 1'b1) got.push_back(bus.exe_rob_idx);
        for (int c = 0; c < 40; c++) begin
            step();
            if (bus.mdr_start === 1'b1) got.push_back(bus.exe_rob_idx);
        end
        checks++;
        if (got.size() != 4) begin
            failures++; $display("FAIL full_issue_count: got %0d want 4", got.size());
        end
        for (int k = 0; k < 4; k++) begin
            if (k < got.size()) begin
                checks++;
                if (got[k] !== want[k]) begin
                    failures++; $display("FAIL full_order k%0d: got rob %0d want %0d", k, got[k], want[k]);
                end
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_flush();
        do_reset();
        mul_lat = 12;
        set_disp(3'd0, 3'd1, 1'b1, 3'd0, 32'd5, 1'b1, 3'd0, 32'd5);
        step();                         // cycle 1
        set_disp(3'd0, 3'd2, 1'b0, 3'd4, 32'd0, 1'b1, 3'd0, 32'd1);
        step();                         // cycle 2
        checks++;
        if (bus.mdr_start !== 1'b1) begin
            failures++; $display("FAIL flush_first_start: got %b want 1", bus.mdr_start);
        end
        set_disp(3'd0, 3'd3, 1'b0, 3'd4, 32'd0, 1'b1, 3'd0, 32'd2);
        step();                         // cycle 3
        clear_inputs();
        step();
        step();                         // cycle 5
        bus.flush = 1'b1;
        checks++;
        if (bus.mdr_squash !== 1'b0) begin
            failures++; $display("FAIL flush_squash_pre: got %b want 0", bus.mdr_squash);
        end
        step();                         // cycle 6: broadcast that would wake the flushed ops
        clear_inputs();
        bus.cdb_valid = 1'b1; bus.cdb_tag = 3'd4; bus.cdb_data = 32'h55;
        for (int c = 6; c <= 14; c++) begin
            checks++;
            if (bus.mdr_squash !== 1'b1 || bus.mdr_start !== 1'b0) begin
                failures++; $display("FAIL flush_inflight c%0d: got squash=%b start=%b want 1 0", c,
                    bus.mdr_squash, bus.mdr_start);
            end
            step();
            clear_inputs();
        end
        for (int c = 15; c <= 24; c++) begin
            checks++;
            if (bus.mdr_squash !== 1'b0 || bus.mdr_start !== 1'b0) begin
                failures++; $display("FAIL flush_after c%0d: got squash=%b start=%b want 0 0", c,
                    bus.mdr_squash, bus.mdr_start);
            end
            step();
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_order();
        logic [2:0] got[$];
        logic [2:0] want[2];
`ifdef MDR_RS_AGE_EN
        want = '{3'd3, 3'd4};
`else
        want = '{3'd4, 3'd3};
`endif
        do_reset();
        mul_lat = 4;
        set_disp(3'd0, 3'd6, 1'b1, 3'd0, 32'd1, 1'b1, 3'd0, 32'd1);
        step();                         // cycle 1: rob 3 goes to entry 1
        set_disp(3'd0, 3'd3, 1'b1, 3'd0, 32'd3, 1'b1, 3'd0, 32'd3);
        step();                         // cycle 2: entry 0 free again, rob 4 lands there
        checks++;
        if (bus.mdr_start !== 1'b1 || bus.exe_rob_idx !== 3'd6) begin
            failures++; $display("FAIL order_first: got start=%b rob=%0d want 1 6", bus.mdr_start, bus.exe_rob_idx);
        end
        set_disp(3'd0, 3'd4, 1'b1, 3'd0, 32'd4, 1'b1, 3'd0, 32'd4);
        step();
        clear_inputs();
        for (int c = 0; c < 30; c++) begin
            if (bus.mdr_start === 1'b1) got.push_back(bus.exe_rob_idx);
            step();
        end
        checks++;
        if (got.size() != 2) begin
            failures++; $display("FAIL order_count: got %0d want 2", got.size());
        end else begin
            checks++;
            if (got[0] !== want[0] || got[1] !== want[1]) begin
                failures++; $display("FAIL order_seq: got %0d,%0d want %0d,%0d", got[0], got[1], want[0], want[1]);
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Randomized traffic against a model: entries held in slots, allocation
    // to the lowest free slot, selection by slot index or dispatch sequence.
    task automatic test_random();
        bit          m_v   [DEPTH];
        bit          m_r1  [DEPTH];
        bit          m_r2  [DEPTH];
        logic [2:0]  m_f3  [DEPTH];
        logic [2:0]  m_rob [DEPTH];
        logic [2:0]  m_t1  [DEPTH];
        logic [2:0]  m_t2  [DEPTH];
        logic [31:0] m_d1  [DEPTH];
        logic [31:0] m_d2  [DEPTH];
        int          m_seq [DEPTH];
        int          seq_ctr = 0;
        bit          m_busy = 1'b0, m_start = 1'b0, m_squash = 1'b0, was_busy;
        logic [69:0] m_iss = '0;
        int          n_used, sel, slot;
        bit          fire;

        do_reset();
        for (int k = 0; k < DEPTH; k++) begin
            m_v[k] = 1'b0; m_r1[k] = 1'b0; m_r2[k] = 1'b0; m_seq[k] = 0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            n_used = 0;
            for (int k = 0; k < DEPTH; k++) if (m_v[k]) n_used++;

            checks++;
            if (bus.disp_ready !== (n_used < DEPTH)) begin
                failures++; $display("FAIL rnd_ready cyc%0d: got %b want %b", cyc, bus.disp_ready, n_used < DEPTH);
            end
            checks++;
            if (bus.mdr_start !== m_start) begin
                failures++; $display("FAIL rnd_start cyc%0d: got %b want %b", cyc, bus.mdr_start, m_start);
            end
            checks++;
            if (bus.mdr_squash !== m_squash) begin
                failures++; $display("FAIL rnd_squash cyc%0d: got %b want %b", cyc, bus.mdr_squash, m_squash);
            end
            checks++;
            if ({bus.mdr_funct3, bus.exe_rob_idx, bus.mdr_rs1_data, bus.mdr_rs2_data} !== m_iss) begin
                failures++; $display("FAIL rnd_issue cyc%0d: got %h want %h", cyc,
                    {bus.mdr_funct3, bus.exe_rob_idx, bus.mdr_rs1_data, bus.mdr_rs2_data}, m_iss);
            end

            // Stimulus for this cycle
            bus.disp_valid   = ($urandom_range(0, 1) == 1);
            bus.disp_funct3  = 3'($urandom_range(0, 7));
            bus.disp_rob_idx = 3'($urandom_range(0, 7));
            bus.disp_rs1_rdy = ($urandom_range(0, 1) == 1);
            bus.disp_rs1_tag = 3'($urandom_range(0, 3));
            bus.disp_rs1_val = $urandom;
            bus.disp_rs2_rdy = ($urandom_range(0, 1) == 1);
            bus.disp_rs2_tag = 3'($urandom_range(0, 3));
            bus.disp_rs2_val = $urandom;
            bus.cdb_valid    = ($urandom_range(0, 4) < 2);
            bus.cdb_tag      = 3'($urandom_range(0, 3));
            bus.cdb_data     = $urandom;
            bus.flush        = (bus.mdr_o_valid !== 1'b1) && ($urandom_range(0, 39) == 0);

            // Model next state
            fire = bus.disp_valid && (n_used < DEPTH) && !bus.flush;
            sel  = -1;
            if (!bus.flush && (!m_busy || bus.mdr_o_valid)) begin
                for (int k = 0; k < DEPTH; k++) begin
                    if (m_v[k] && m_r1[k] && m_r2[k]) begin
`ifdef MDR_RS_AGE_EN
                        if (sel < 0 || m_seq[k] < m_seq[sel]) sel = k;
`else
                        if (sel < 0) sel = k;
`endif
                    end
                end
            end
            slot = -1;
            for (int k = 0; k < DEPTH; k++) if (!m_v[k] && slot < 0) slot = k;

            was_busy = m_busy;
            if (was_busy && bus.mdr_o_valid) m_squash = 1'b0;
            else if (was_busy && bus.flush)  m_squash = 1'b1;

            if (sel >= 0) begin
                m_iss    = {m_f3[sel], m_rob[sel], m_d1[sel], m_d2[sel]};
                m_v[sel] = 1'b0;
                m_busy   = 1'b1;
            end else if (was_busy && bus.mdr_o_valid) begin
                m_busy = 1'b0;
            end
            m_start = (sel >= 0);

            if (bus.cdb_valid) begin
                for (int k = 0; k < DEPTH; k++) begin
                    if (m_v[k] && !m_r1[k] && m_t1[k] == bus.cdb_tag) begin m_r1[k] = 1'b1; m_d1[k] = bus.cdb_data; end
                    if (m_v[k] && !m_r2[k] && m_t2[k] == bus.cdb_tag) begin m_r2[k] = 1'b1; m_d2[k] = bus.cdb_data; end
                end
            end
            if (bus.flush) for (int k = 0; k < DEPTH; k++) m_v[k] = 1'b0;

            if (fire && slot >= 0) begin
                m_v[slot]   = 1'b1;
                m_f3[slot]  = bus.disp_funct3;
                m_rob[slot] = bus.disp_rob_idx;
                m_t1[slot]  = bus.disp_rs1_tag;
                m_t2[slot]  = bus.disp_rs2_tag;
                m_r1[slot]  = bus.disp_rs1_rdy || (bus.cdb_valid && bus.cdb_tag == bus.disp_rs1_tag);
                m_r2[slot]  = bus.disp_rs2_rdy || (bus.cdb_valid && bus.cdb_tag == bus.disp_rs2_tag);
                m_d1[slot]  = bus.disp_rs1_rdy ? bus.disp_rs1_val : bus.cdb_data;
                m_d2[slot]  = bus.disp_rs2_rdy ? bus.disp_rs2_val : bus.cdb_data;
                m_seq[slot] = seq_ctr;
                seq_ctr++;
            end

            mul_lat = $urandom_range(1, 5);
            step();
        end
        clear_inputs();
    endtask

    // ------------------------------------------------------------------
    initial begin
        clear_inputs();
        bus.mdr_o_valid = 1'b0;
        test_reset();
        test_latency();
        test_wakeup();
        test_bypass();
        test_full();
        test_flush();
        test_order();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
